// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM states, fn3 access codes and
// the legality / store-lane helpers used when an access is accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    // An access is legal when the width code exists, the address is naturally
    // aligned for that width, and it is not a store using an unsigned code.
    function automatic logic access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] code,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b1;
        case (code)
            FN3_B, FN3_BU: ok = 1'b1;
            FN3_H, FN3_HU: ok = ~off[0];
            FN3_W:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        if (rd && wr) begin
            ok = 1'b0;
        end
        if (wr && code[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(
        input logic [2:0] code,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (code[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across every lane so the byte enables alone
    // pick the bytes that land in memory.
    function automatic logic [31:0] lane_wdata(
        input logic [2:0]  code,
        input logic [31:0] data
    );
        logic [31:0] wd;
        case (code[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it
// according to the load width code.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  fn3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (fn3)
            FN3_B:   result = {{24{byte_sel[7]}}, byte_sel};
            FN3_BU:  result = {24'd0, byte_sel};
            FN3_H:   result = {{16{half_sel[15]}}, half_sel};
            FN3_HU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Load/store unit between execute and a req/gnt/rvalid data memory port.
// One access in flight; all fields are captured in IDLE and held until DONE.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      fn3,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] load_data,
    output logic            stall,
    output logic            done,
    output logic            access_err
);

    mem_state_e      state_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;
    logic [1:0]      off_q;
    logic [2:0]      fn3_q;
    logic [XLEN-1:0] load_data_q;
    logic            done_q;
    logic            err_q;

    logic            access_req;
    logic            access_ok;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] aligned;

    assign access_req = mem_read | mem_write;
    assign access_ok  = access_legal(mem_read, mem_write, fn3, alu_out[1:0]);

    always_comb begin
        be_d    = lane_be(fn3, alu_out[1:0]);
        wdata_d = mem_write ? lane_wdata(fn3, rs2_data) : '0;
    end

    // Legality is only judged in IDLE; once accepted, the access keeps the
    // core held regardless of what the inputs do.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:      stall = access_req & access_ok;
            REQ, WAIT: stall = access_req;
            default:   stall = 1'b0;
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (off_q),
        .fn3    (fn3_q),
        .result (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            off_q       <= 2'b00;
            fn3_q       <= FN3_W;
            load_data_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        if (access_ok) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= {alu_out[XLEN-1:2], 2'b00};
                            off_q   <= alu_out[1:0];
                            fn3_q   <= fn3;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        load_data_q <= aligned;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign load_data  = load_data_q;
    assign done       = done_q;
    assign access_err = err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 alu_out  in  32  effective address from execution stage.
REQ-005 rs2_data  in  32  store data.
REQ-006 fn3  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 mem_read, mem_write  in  1 each  access request from control.
REQ-008 dmem_req, dmem_we  out  1 each  memory request and write strobe.
REQ-009 dmem_addr  out  32  word-aligned address ({alu_out[31:2],2'b00}).
REQ-010 dmem_wdata  out  32;  dmem_be  out  4  lane-replicated write data and byte enables.
REQ-011 dmem_gnt, dmem_rvalid  in  1 each;  dmem_rdata  in  32  memory handshake and read data.
REQ-012 load_data  out  32  aligned, extended load result.
REQ-013 stall  out  1;  done  out  1;  access_err  out  1  core hold, completion pulse, illegal-access pulse.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: (mem_read|mem_write) and legal -> latch address, fn3, be, wdata, we; go to REQ next cycle.
REQ-016 REQ: dmem_req=1 with latched fields held stable until dmem_gnt; store+gnt -> DONE; load+gnt -> WAIT.
REQ-017 WAIT: dmem_req=0; dmem_rvalid -> register extracted load_data, go to DONE; otherwise stay indefinitely.
REQ-018 DONE: done=1 for exactly one cycle, stall=0, then IDLE unconditionally.
REQ-019 stall SHALL be combinational: 1 when (mem_read|mem_write) and state!=DONE and access is legal.
REQ-020 Minimum latency: store 2 cycles request-to-done (gnt in first REQ cycle); load 3 cycles (rvalid in first WAIT cycle).
REQ-021 Illegal access: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; fn3 011/110/111; mem_read&mem_write both high; store with fn3[2]=1 -- SHALL pulse access_err one cycle in IDLE, issue no request, stall=0.
REQ-022 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
REQ-023 Load extraction: byte/half selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-024 load_data SHALL hold its last value until the next load completes; stores do not modify it.
REQ-025 dmem_gnt/dmem_rvalid outside REQ/WAIT respectively SHALL be ignored.
REQ-026 Input changes while state!=IDLE SHALL NOT affect the in-flight access.

Reset
REQ-027 rst SHALL force state=IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, load_data=0, done=0, access_err=0 on the next edge.
REQ-028 rst mid-access (REQ or WAIT) SHALL abandon the access; a later rvalid SHALL be ignored.

Structure
REQ-029 A shared package mem_pkg SHALL hold the state enum and fn3 width constants (FN3_B, FN3_H, FN3_W, FN3_BU, FN3_HU).
REQ-030 One combinational sub-module load_align SHALL implement REQ-023 (inputs rdata, addr[1:0], fn3; output 32-bit result).

Verification
REQ-031 SW alu_out=0x100, rs2=0xDEADBEEF, gnt same cycle -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, done 2 cycles after request, stall high 2 cycles.
REQ-032 SB alu_out=0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
REQ-033 LB alu_out=0x101, rdata=0x0000F000, rvalid after 3 WAIT cycles -> load_data=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-034 LW alu_out=0x102 -> access_err pulse, dmem_req never asserted, stall=0; fn3=011 same.
REQ-035 LH alu_out=0x100 with gnt withheld 4 cycles -> dmem_req held with stable addr; alu_out changed to 0x200 mid-wait -> dmem_addr stays 0x100.
REQ-036 rst asserted in WAIT, then rvalid with 0x12345678 -> state IDLE, load_data=0, done never pulses.
